// File: rtl/shiftreg_pkg.sv
// Shared types and frame sizing for the PISO serializer; SHIFTREG_PISO_PARITY_EN
// lengthens every frame by one even-parity bit.
package shiftreg_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int WIDTH_DEF = 4;

  function automatic int frame_len(input int width);
`ifdef SHIFTREG_PISO_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  // Counter width covering 0..FRAME-1, never narrower than one bit.
  function automatic int cnt_bits(input int width);
    return (frame_len(width) <= 1) ? 1 : $clog2(frame_len(width));
  endfunction

endpackage

// File: rtl/shiftreg_piso_if.sv
// Load handshake plus framed serial output of the PISO serializer.
interface shiftreg_piso_if #(
  parameter int WIDTH = shiftreg_pkg::WIDTH_DEF
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] data_in;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_last;

  modport master (
    output load_valid, data_in,
    input  load_ready, ser_out, ser_valid, ser_last
  );

  modport slave (
    input  load_valid, data_in,
    output load_ready, ser_out, ser_valid, ser_last
  );
endinterface

// File: rtl/shiftreg_bitcnt.sv
// Loadable frame bit counter; wraps to 0 after TC_VAL, o_tc flags the final bit.
// Zero latency on o_tc; no backpressure (advances whenever i_en is high).
module shiftreg_bitcnt #(
  parameter int CW     = 1,
  parameter int TC_VAL = 0
) (
  input  logic clk,
  input  logic clear,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc
);
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (clear || i_load) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tc ? '0 : r_cnt + CW'(1);
    end
  end

  assign o_tc = (r_cnt == CW'(TC_VAL));
endmodule

// File: rtl/shiftreg_piso.sv
// Serializes a WIDTH-bit word MSB first, first bit one cycle after accept; load_ready
// only in IDLE or on the last bit. SHIFTREG_PISO_PARITY_EN appends an even-parity bit.
module shiftreg_piso
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic            clk,
  input logic            clear,
  shiftreg_piso_if.slave bus
);
  localparam int FRAME = frame_len(WIDTH);
  localparam int CW    = cnt_bits(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [FRAME-1:0] r_sh;
  logic [FRAME-1:0] w_word;
  logic             w_tc;
  logic             w_last;
  logic             w_ready;
  logic             w_accept;

`ifdef SHIFTREG_PISO_PARITY_EN
  assign w_word = {bus.data_in, ^bus.data_in};
`else
  assign w_word = bus.data_in;
`endif

  // The counter idles at 0, which for a one-bit frame already reads as terminal.
  assign w_last   = (r_state == SHIFT) && w_tc;
  assign w_ready  = !clear && ((r_state == IDLE) || w_last);
  assign w_accept = bus.load_valid && w_ready;

  shiftreg_bitcnt #(
    .CW     (CW),
    .TC_VAL (FRAME - 1)
  ) u_bitcnt (
    .clk    (clk),
    .clear  (clear),
    .i_load (w_accept),
    .i_en   (r_state == SHIFT),
    .o_tc   (w_tc)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = SHIFT;
      SHIFT:   if (w_last && !w_accept) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Zero fill means the register is already empty when a frame ends.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_sh <= '0;
    end else if (w_accept) begin
      r_sh <= w_word;
    end else if (r_state == SHIFT) begin
      r_sh <= r_sh << 1;
    end
  end

  always_comb begin
    bus.load_ready = w_ready;
    bus.ser_valid  = (r_state == SHIFT);
    bus.ser_last   = w_last;
    bus.ser_out    = (r_state == SHIFT) && r_sh[FRAME-1];
  end
endmodule

// File: tb/tb_shiftreg_piso.sv
// Directed scoreboard bench for shiftreg_piso at WIDTH=4, with or without parity.
module tb_shiftreg_piso;
  localparam int WIDTH = 4;
`ifdef SHIFTREG_PISO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  logic clk;
  logic clear;
  int   n_pass;
  int   n_total;
  logic [1:0] exp_q[$];
  logic [1:0] mon_e;
  int   waits;

  shiftreg_piso_if #(.WIDTH(WIDTH)) bus ();

  shiftreg_piso #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Scoreboard monitor: every valid serial bit must match the head of the queue.
  always @(negedge clk) begin
    if (bus.ser_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected serial bit: got ser_out=%0b, expected no valid bit", bus.ser_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ser_out", {31'd0, bus.ser_out}, {31'd0, mon_e[1]});
        chk("ser_last", {31'd0, bus.ser_last}, {31'd0, mon_e[0]});
      end
    end
  end

  // bits: hand-computed frame MSB first; the low bit is the parity bit.
  task automatic send(input logic [3:0] w, input logic [4:0] bits, output int nw);
    bus.load_valid = 1'b1;
    bus.data_in    = w;
    nw = 0;
    do begin
      @(negedge clk);
      nw++;
    end while (bus.load_ready !== 1'b1 && nw < 50);
    if (bus.load_ready !== 1'b1) begin
      chk("load accept timeout", 32'(nw), 32'(FRAME));
      bus.load_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      for (int k = 0; k < FRAME; k++) exp_q.push_back({bits[4-k], k == FRAME - 1});
      bus.load_valid = 1'b0;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string name);
    @(negedge clk);
    chk({name, " ser_valid"}, {31'd0, bus.ser_valid}, 32'd0);
    chk({name, " ser_out"}, {31'd0, bus.ser_out}, 32'd0);
    chk({name, " ser_last"}, {31'd0, bus.ser_last}, 32'd0);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    clear = 1'b1;
    bus.load_valid = 1'b0;
    bus.data_in = '0;

    // Reset state
    next_cycle();
    chk_idle("reset");
    chk("reset load_ready", {31'd0, bus.load_ready}, 32'd0);
    next_cycle();
    clear = 1'b0;
    @(negedge clk);
    chk("ready after clear", {31'd0, bus.load_ready}, 32'd1);
    next_cycle();

    // Single word 1011: four valid cycles, ready only with the last bit
    send(4'b1011, 5'b10111, waits);
    chk("single accept wait", 32'(waits), 32'd1);
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      chk("single ser_valid", {31'd0, bus.ser_valid}, 32'd1);
      chk("single load_ready", {31'd0, bus.load_ready}, (k == FRAME) ? 32'd1 : 32'd0);
      next_cycle();
    end
    chk_idle("after single");
    next_cycle();

    // Back-to-back 1011 then 0100 with no gap
    send(4'b1011, 5'b10111, waits);
    send(4'b0100, 5'b01001, waits);
    chk("b2b second accept cycle", 32'(waits), 32'(FRAME));
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      chk("b2b ser_valid", {31'd0, bus.ser_valid}, 32'd1);
      next_cycle();
    end
    chk_idle("after b2b");
    next_cycle();

    // Busy ignore: 1111 held valid during a 0000 frame
    send(4'b0000, 5'b00000, waits);
    send(4'b1111, 5'b11110, waits);
    chk("busy accept cycle", 32'(waits), 32'(FRAME));
    repeat (FRAME + 2) next_cycle();

    // Reset mid-frame: clear in cycle N+2 drops the remaining bits
    send(4'b1011, 5'b10111, waits);
    next_cycle();
    clear = 1'b1;
    next_cycle();
    exp_q.delete();
    chk_idle("mid-frame clear");
    chk("clear load_ready", {31'd0, bus.load_ready}, 32'd0);
    next_cycle();
    clear = 1'b0;
    @(negedge clk);
    chk("ready after mid clear", {31'd0, bus.load_ready}, 32'd1);
    chk("idle after mid clear", {31'd0, bus.ser_valid}, 32'd0);
    repeat (FRAME + 2) next_cycle();

    // Clear wins over a simultaneous load
    clear = 1'b1;
    bus.load_valid = 1'b1;
    bus.data_in = 4'b1111;
    next_cycle();
    clear = 1'b0;
    bus.load_valid = 1'b0;
    chk_idle("clear vs load");
    chk("clear vs load ready", {31'd0, bus.load_ready}, 32'd1);
    repeat (FRAME + 2) next_cycle();

`ifdef SHIFTREG_PISO_PARITY_EN
    send(4'b1011, 5'b10111, waits);
    repeat (FRAME + 1) next_cycle();
    send(4'b0000, 5'b00000, waits);
    repeat (FRAME + 1) next_cycle();
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) next_cycle();
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/shiftreg_piso.md
# shiftreg_piso

Parallel-in, serial-out shift register that serializes a WIDTH-bit word onto a single-bit line, one bit per clock, MSB first. It is the transmit end of the serial-in shift-register chain: its `ser_out` drives the serial input of a receiving shift register, and it frames each word with a valid/last strobe. A ready/valid load handshake accepts the next word on the final bit cycle, so consecutive words stream with no idle cycles.

## Interface
Parameters:
- `WIDTH`, default 4: data bits per word; legal range 1..32.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge only.
- `clear`  in  1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `load_valid`  in  1: `data_in` holds a word to send.
- `load_ready`  out  1: block can accept a word this cycle.
- `data_in`  in  WIDTH: parallel word; sampled only on an accepted load.
- `ser_out`  out  1: serial data bit.
- `ser_valid`  out  1: `ser_out` carries a frame bit this cycle.
- `ser_last`  out  1: high with the final bit of a frame.

## Operation
- States: IDLE (no frame) and SHIFT (frame in progress). A bit counter runs 0..FRAME-1, where FRAME = WIDTH, or WIDTH+1 with parity enabled.
- Load accept: `load_valid && load_ready` at a rising edge. The word is captured into the shift register, the counter is set to 0, and the state moves to SHIFT.
- `load_ready` = 1 in IDLE. In SHIFT it is 1 only on the cycle where `ser_last` = 1. It is 0 while `clear` = 1. It is derived from state only and never depends on `load_valid`.
- In SHIFT:
  - `ser_out` = current register MSB. Each edge shifts the register left by one, fills with 0, and increments the counter.
  - Frame bit k (k = 0..WIDTH-1) is `data_in[WIDTH-1-k]`.
- End of frame: on the edge where `ser_last` = 1,
  - a new load accepted on that edge starts its frame on the next cycle with no gap;
  - otherwise the state returns to IDLE.
- Loads presented while `load_ready` = 0 are ignored; the source must hold `load_valid` and `data_in` stable until accepted.
- IDLE outputs: `ser_out` = 0, `ser_valid` = 0, `ser_last` = 0.
- Reset:
  - `clear` = 1 at an edge puts the block in IDLE, zeroes the shift register and counter, and discards any in-flight frame.
  - `clear` takes priority over a simultaneous load.
  - Reset values: `ser_out` 0, `ser_valid` 0, `ser_last` 0, `load_ready` 0 while `clear` is high and 1 on the first cycle after it drops.
- WIDTH = 1: every frame is one cycle long, and `ser_last` is always high whenever `ser_valid` is high.

## Timing
- Accept at edge N means bit 0 is driven in cycle N+1, and the last bit in cycle N+FRAME.
- `ser_out`, `ser_valid` and `ser_last` are registered, with no combinational path from inputs.
- Throughput is one bit per cycle. Back-to-back frames are contiguous: `ser_valid` stays high across the frame boundary.

## Configuration
- `SHIFTREG_PISO_PARITY_EN`
  - Defined: one even-parity bit is appended after the data bits. Its value is the XOR of the captured word. It is driven in cycle N+WIDTH+1, and `ser_last` moves to that bit.
  - Undefined: frames are exactly WIDTH bits and no parity logic is built.

## Structure
- Shared package `shiftreg_pkg`:
  - the state enum (IDLE, SHIFT);
  - the `WIDTH` default constant;
  - a helper constant/function for the frame length, used to size the counter (clog2 of FRAME, minimum 1 bit).
- One sub-module, `shiftreg_bitcnt`:
  - loadable up-counter with terminal-count output;
  - its terminal count drives `ser_last` and `load_ready`.

## Test plan
- Single word: WIDTH=4, load 4'b1011 at edge N. Expect `ser_out` = 1,0,1,1 in cycles N+1..N+4, `ser_valid` high for those 4 cycles, `ser_last` only at N+4, `load_ready` low at N+1..N+3.
- Back-to-back: load 4'b1011, then hold 4'b0100 valid. Expect 8 contiguous valid bits 1,0,1,1,0,1,0,0, with the second accept on the edge ending cycle N+4.
- Busy ignore: assert `load_valid` with 4'b1111 during cycles N+1..N+3 of a 4'b0000 frame. Expect serial output 0,0,0,0, then 1,1,1,1 starting at N+5.
- Reset mid-frame: assert `clear` in cycle N+2 of 4'b1011. After that edge, expect all outputs 0 and no remaining bits emitted; `load_ready` = 1 in the first cycle after `clear` falls.
- Reset vs load: `clear` and an accepted-looking load at the same edge. Expect the block to stay in IDLE with `ser_valid` = 0.
- Parity (macro defined): load 4'b1011. Expect bits 1,0,1,1,1, with `ser_last` on the 5th bit. Load 4'b0000: expect parity bit 0.
